grid_step_scheduler: RTL and testbench

- Central sequencer for the array of heat-grid column engines.
- Waits for every column to finish memory init, then broadcasts a one-cycle start pulse per row update and collects all column done flags before issuing the next.
- Tracks the current row, counts completed sweeps (time steps), and supports free-run, single-step and iteration-limited operation for the VGA/HPS side.

---
 rtl/grid_step_scheduler.sv | 170 +++++++++++++++++
 tb/tb_grid_step_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_step_scheduler.sv
// grid_step_scheduler: central row/sweep sequencer for the heat-grid column
// engines. Waits for every column to finish memory init, then broadcasts one
// col_start per row update and collects all col_done flags before issuing the
// next row. Tracks the row index, counts completed sweeps and supports
// free-run (run), single-sweep (step) and iteration-limited (max_iters) use.
//
// Optional feature: define GRID_WATCHDOG_EN to add a WAIT_DONE watchdog that
// parks the scheduler in FAULT when the columns stop answering.
module grid_step_scheduler #(
  parameter int NCOLS     = 16,
  parameter int ROW_BITS  = 8,
  parameter int ITER_BITS = 16,
  parameter int WD_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROW_BITS-1:0]  height,
  input  logic                 run,
  input  logic                 step,
  input  logic [ITER_BITS-1:0] max_iters,
  input  logic                 clear_halt,
  input  logic [NCOLS-1:0]     col_init,
  input  logic [NCOLS-1:0]     col_done,
  output logic                 col_start,
  output logic [ROW_BITS-1:0]  row_idx,
  output logic [ITER_BITS-1:0] iter_count,
  output logic                 sweep_done,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault
);

  typedef enum logic [2:0] {
    S_INIT,
    S_READY,
    S_ISSUE,
    S_ARM,
    S_WAIT_DONE,
    S_ADVANCE,
    S_HALTED
`ifdef GRID_WATCHDOG_EN
    , S_FAULT
`endif
  } state_t;

  // A zero-length watchdog window is meaningless; reject it at elaboration.
  if (WD_CYCLES < 1) begin : g_wd_check
    $error("grid_step_scheduler: WD_CYCLES must be at least 1");
  end

  state_t               state, state_nxt;
  logic [ROW_BITS-1:0]  height_q;   // height frozen for the sweep in progress
  logic                 step_pend;  // single-sweep request still outstanding
  logic                 all_init, all_done, at_top, limit_hit, go;
  logic [ITER_BITS-1:0] iter_inc;

  assign all_init  = &col_init;
  assign all_done  = &col_done;
  assign at_top    = (row_idx == height_q);
  assign iter_inc  = iter_count + ITER_BITS'(1);
  assign limit_hit = (max_iters != '0) && (iter_inc == max_iters);
  assign go        = run || step || step_pend;

`ifdef GRID_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // Last WAIT_DONE cycle of the window: the next edge would be WD_CYCLES cycles.
  assign wd_expire = (wd_cnt == WD_W'(WD_CYCLES - 1));

  // Watchdog counter: cleared in ARM so it restarts on every WAIT_DONE entry.
  always_ff @(posedge clk) begin
    if (reset)                     wd_cnt <= '0;
    else if (state == S_ARM)       wd_cnt <= '0;
    else if (state == S_WAIT_DONE) wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign fault = (state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first, so paths that do not assign state_nxt hold the
    // current state instead of inferring a latch.
    state_nxt = state;
    case (state)
      S_INIT:      if (all_init) state_nxt = S_READY;
      S_READY:     if (go) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_ARM;
      // ARM is a guard cycle that lets the stale done flags from the previous
      // row drop before WAIT_DONE looks at them.
      S_ARM:       state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (all_done) state_nxt = S_ADVANCE;
`ifdef GRID_WATCHDOG_EN
        else if (wd_expire) state_nxt = S_FAULT;
`endif
      end
      // The limit and run checks only act on a row wrap, so sweeps are never
      // truncated mid-way.
      S_ADVANCE: begin
        if (at_top && limit_hit) state_nxt = S_HALTED;
        else if (at_top && !run) state_nxt = S_READY;
        else                     state_nxt = S_ISSUE;
      end
      S_HALTED:    if (clear_halt) state_nxt = S_READY;
`ifdef GRID_WATCHDOG_EN
      S_FAULT:     state_nxt = S_FAULT;
`endif
      default:     state_nxt = S_INIT;
    endcase
  end

  // Row / sweep bookkeeping, step latch and sweep_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx    <= '0;
      iter_count <= '0;
      sweep_done <= 1'b0;
      step_pend  <= 1'b0;
      height_q   <= '0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_READY: begin
          // height tracks the input while idle and is frozen once a sweep starts.
          height_q <= height;
          if (run)       step_pend <= 1'b0;
          else if (step) step_pend <= 1'b1;
        end
        S_ADVANCE: begin
          if (at_top) begin
            row_idx    <= '0;
            iter_count <= iter_inc;
            sweep_done <= 1'b1;
            step_pend  <= 1'b0;
            height_q   <= height;
          end else begin
            row_idx <= row_idx + ROW_BITS'(1);
          end
        end
        S_HALTED: begin
          if (clear_halt) begin
            iter_count <= '0;
            row_idx    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Start is gated by reset so a reset landing in ISSUE drops it at once.
  assign col_start = (state == S_ISSUE) && !reset;
  assign busy      = (state == S_ISSUE) || (state == S_ARM) || (state == S_WAIT_DONE);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_grid_step_scheduler.sv
// Testbench for grid_step_scheduler: behavioural column engines, a negedge
// monitor feeding observation queues, and per-scenario tasks that push the
// expected row/sweep sequence and compare it against what was observed.
module tb_grid_step_scheduler;
  localparam int NCOLS     = 16;
  localparam int ROW_BITS  = 8;
  localparam int ITER_BITS = 16;
  localparam int WD_CYCLES = 20;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ROW_BITS-1:0]  height;
  logic                 run, step, clear_halt;
  logic [ITER_BITS-1:0] max_iters;
  logic [NCOLS-1:0]     col_init, col_done;
  logic                 col_start, sweep_done, busy, halted, fault;
  logic [ROW_BITS-1:0]  row_idx;
  logic [ITER_BITS-1:0] iter_count;

  grid_step_scheduler #(
    .NCOLS(NCOLS), .ROW_BITS(ROW_BITS), .ITER_BITS(ITER_BITS), .WD_CYCLES(WD_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .height(height), .run(run), .step(step),
    .max_iters(max_iters), .clear_halt(clear_halt), .col_init(col_init),
    .col_done(col_done), .col_start(col_start), .row_idx(row_idx),
    .iter_count(iter_count), .sweep_done(sweep_done), .busy(busy),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Column engine model: done drops on start, rises lat[i] cycles later and
  // stays high until the next start; stuck columns never complete.
  int         lat [NCOLS];
  int         cnt [NCOLS];
  logic [NCOLS-1:0] stuck;

  always @(posedge clk) begin
    for (int i = 0; i < NCOLS; i++) begin
      if (reset) begin
        col_done[i] <= 1'b0;
        cnt[i]      <= 0;
      end else if (col_start) begin
        col_done[i] <= 1'b0;
        cnt[i]      <= lat[i];
      end else if (cnt[i] > 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1 && !stuck[i]) col_done[i] <= 1'b1;
      end
    end
  end

  // Scoreboard queues.
  logic [ROW_BITS-1:0]  exp_rows [$];
  logic [ROW_BITS-1:0]  obs_rows [$];
  logic [ITER_BITS-1:0] exp_iters [$];
  logic [ITER_BITS-1:0] obs_iters [$];
  int                   obs_gaps [$];
  int                   rise_cyc = 0;
  bit                   rise_pending = 1'b0;
  bit                   prev_and = 1'b0;

  // Monitor: records row at each start, iter at each sweep_done, and the
  // distance from the last all-done rise to the following start.
  always @(negedge clk) begin
    if (reset) begin
      prev_and = 1'b0;
    end else begin
      if (col_start) begin
        obs_rows.push_back(row_idx);
        if (rise_pending) begin
          obs_gaps.push_back(cyc - rise_cyc);
          rise_pending = 1'b0;
        end
      end
      if (sweep_done) obs_iters.push_back(iter_count);
      if ((&col_done) && !prev_and) begin
        rise_cyc     = cyc;
        rise_pending = 1'b1;
      end
      prev_and = &col_done;
    end
  end

  task automatic clear_sb();
    exp_rows.delete(); obs_rows.delete();
    exp_iters.delete(); obs_iters.delete();
    obs_gaps.delete(); rise_pending = 1'b0;
  endtask

  task automatic set_lat(input int l);
    for (int i = 0; i < NCOLS; i++) lat[i] = l;
  endtask

  task automatic push_sweep(input int h, input int iter);
    for (int r = 0; r <= h; r++) exp_rows.push_back(ROW_BITS'(r));
    exp_iters.push_back(ITER_BITS'(iter));
  endtask

  // Waits until the scheduler has been idle (no busy, no start) for 3 cycles.
  task automatic wait_idle(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && !col_start) quiet++; else quiet = 0;
      if (quiet >= 3) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; step = 1'b0; clear_halt = 1'b0;
    col_init = '1; stuck = '0; max_iters = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clear_sb();
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; clear_halt = 1'b0;
    height = '0; max_iters = '0; col_init = 16'hFFFE; stuck = '0;
    set_lat(2);
    repeat (3) @(negedge clk);
    n_checks++; if (col_start !== 1'b0) $display("FAIL rst_col_start: got %b want 0", col_start); else n_pass++;
    n_checks++; if (row_idx !== '0) $display("FAIL rst_row_idx: got %0d want 0", row_idx); else n_pass++;
    n_checks++; if (iter_count !== '0) $display("FAIL rst_iter_count: got %0d want 0", iter_count); else n_pass++;
    n_checks++; if ({sweep_done, busy, halted, fault} !== 4'b0000)
      $display("FAIL rst_flags: got %b want 0000", {sweep_done, busy, halted, fault}); else n_pass++;
  endtask

  task automatic test_init_gating();
    int  c0 = 0, c1 = 0;
    bit  found = 1'b0, ok;
    reset = 1'b0; run = 1'b1; height = '0; col_init = 16'hFFFE;
    clear_sb();
    repeat (50) @(negedge clk);
    n_checks++; if (obs_rows.size() != 0) $display("FAIL init_no_start: got %0d starts want 0", obs_rows.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL init_busy: got %b want 0", busy); else n_pass++;
    col_init = '1; c0 = cyc;
    // mask sampled -> READY, run sampled -> ISSUE: start in the third cycle
    // counting the one in which the mask completes.
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (col_start) begin found = 1'b1; c1 = cyc; end
    end
    n_checks++; if (!found || (c1 - c0) != 2)
      $display("FAIL init_first_start: got found=%b delay=%0d want delay 2", found, c1 - c0); else n_pass++;
    run = 1'b0;
    wait_idle(200, ok);
    n_checks++; if (!ok) $display("FAIL init_idle: got busy want idle"); else n_pass++;
  endtask

  task automatic test_single_step();
    bit ok;
    do_reset();
    height = 8'd3; set_lat(6);
    push_sweep(3, 1);
    pulse_step();
    wait_idle(300, ok);
    n_checks++; if (!ok) $display("FAIL ss_idle: got busy want idle"); else n_pass++;
    n_checks++; if (obs_rows.size() != exp_rows.size())
      $display("FAIL ss_nstarts: got %0d want %0d", obs_rows.size(), exp_rows.size()); else n_pass++;
    while (exp_rows.size() > 0 && obs_rows.size() > 0) begin
      logic [ROW_BITS-1:0] e = exp_rows.pop_front();
      logic [ROW_BITS-1:0] o = obs_rows.pop_front();
      n_checks++; if (o !== e) $display("FAIL ss_row: got %0d want %0d", o, e); else n_pass++;
    end
    n_checks++; if (obs_iters.size() != 1 || obs_iters[0] !== exp_iters[0])
      $display("FAIL ss_sweep_done: got %0d pulses want 1 with iter 1", obs_iters.size()); else n_pass++;
    n_checks++; if (row_idx !== '0) $display("FAIL ss_row_wrap: got %0d want 0", row_idx); else n_pass++;
    n_checks++; if (iter_count !== 16'd1) $display("FAIL ss_iter: got %0d want 1", iter_count); else n_pass++;
  endtask

  task automatic test_staggered();
    bit ok;
    do_reset();
    height = 8'd2;
    for (int i = 0; i < NCOLS; i++) lat[i] = 3 + 2 * (i % 10);
    push_sweep(2, 1);
    pulse_step();
    wait_idle(400, ok);
    n_checks++; if (!ok) $display("FAIL stag_idle: got busy want idle"); else n_pass++;
    n_checks++; if (obs_rows.size() != exp_rows.size())
      $display("FAIL stag_nstarts: got %0d want %0d", obs_rows.size(), exp_rows.size()); else n_pass++;
    while (exp_rows.size() > 0 && obs_rows.size() > 0) begin
      logic [ROW_BITS-1:0] e = exp_rows.pop_front();
      logic [ROW_BITS-1:0] o = obs_rows.pop_front();
      n_checks++; if (o !== e) $display("FAIL stag_row: got %0d want %0d", o, e); else n_pass++;
    end
    // Last flag rises, WAIT_DONE sees it, ADVANCE, then ISSUE: 2 cycles.
    n_checks++; if (obs_gaps.size() != 2) $display("FAIL stag_ngaps: got %0d want 2", obs_gaps.size()); else n_pass++;
    foreach (obs_gaps[i]) begin
      n_checks++; if (obs_gaps[i] != 2) $display("FAIL stag_gap: got %0d want 2", obs_gaps[i]); else n_pass++;
    end
  endtask

  task automatic test_iter_limit();
    bit ok = 1'b0;
    int n;
    do_reset();
    height = 8'd7; max_iters = 16'd3; set_lat(2);
    for (int s = 1; s <= 3; s++) push_sweep(7, s);
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1'b1;
    end
    n_checks++; if (!ok) $display("FAIL lim_halted: got halted=0 want 1"); else n_pass++;
    n_checks++; if (iter_count !== 16'd3) $display("FAIL lim_iter: got %0d want 3", iter_count); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (obs_rows.size() != 24) $display("FAIL lim_nstarts: got %0d want 24", obs_rows.size()); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL lim_hold: got halted=%b want 1", halted); else n_pass++;
    n = 0;
    while (exp_rows.size() > 0 && obs_rows.size() > 0) begin
      logic [ROW_BITS-1:0] e = exp_rows.pop_front();
      logic [ROW_BITS-1:0] o = obs_rows.pop_front();
      if (o !== e) n++;
    end
    n_checks++; if (n != 0) $display("FAIL lim_rows: got %0d row mismatches want 0", n); else n_pass++;
    while (exp_iters.size() > 0 && obs_iters.size() > 0) begin
      logic [ITER_BITS-1:0] e = exp_iters.pop_front();
      logic [ITER_BITS-1:0] o = obs_iters.pop_front();
      n_checks++; if (o !== e) $display("FAIL lim_sweep_iter: got %0d want %0d", o, e); else n_pass++;
    end
    run = 1'b0; clear_halt = 1'b1;
    @(negedge clk); clear_halt = 1'b0;
    n_checks++; if ({halted, busy} !== 2'b00 || iter_count !== '0)
      $display("FAIL lim_clear: got halted=%b busy=%b iter=%0d want 0 0 0", halted, busy, iter_count); else n_pass++;
    max_iters = '0;
  endtask

  task automatic test_run_drop();
    bit ok = 1'b0;
    do_reset();
    height = 8'd5; set_lat(3);
    push_sweep(5, 1);
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (col_start && row_idx == 8'd2) ok = 1'b1;
    end
    // Drop run and shrink height mid-sweep: the sweep must still reach row 5.
    run = 1'b0; height = 8'd1;
    n_checks++; if (!ok) $display("FAIL drop_row2: got no start at row 2 want one"); else n_pass++;
    wait_idle(300, ok);
    n_checks++; if (!ok) $display("FAIL drop_idle: got busy want idle"); else n_pass++;
    push_sweep(1, 2);
    pulse_step();
    wait_idle(300, ok);
    n_checks++; if (obs_rows.size() != exp_rows.size())
      $display("FAIL drop_nstarts: got %0d want %0d", obs_rows.size(), exp_rows.size()); else n_pass++;
    while (exp_rows.size() > 0 && obs_rows.size() > 0) begin
      logic [ROW_BITS-1:0] e = exp_rows.pop_front();
      logic [ROW_BITS-1:0] o = obs_rows.pop_front();
      n_checks++; if (o !== e) $display("FAIL drop_row: got %0d want %0d", o, e); else n_pass++;
    end
    n_checks++; if (obs_iters.size() != 2) $display("FAIL drop_nsweeps: got %0d want 2", obs_iters.size()); else n_pass++;
    n_checks++; if (iter_count !== 16'd2) $display("FAIL drop_iter: got %0d want 2", iter_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    int n;
    do_reset();
    height = 8'd3; set_lat(30);
    pulse_step();
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (col_start && row_idx == 8'd1) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
    n_checks++; if (!ok || busy !== 1'b1 || col_start !== 1'b0)
      $display("FAIL rmid_in_wait: got ok=%b busy=%b start=%b want 1 1 0", ok, busy, col_start); else n_pass++;
    reset = 1'b1; col_init = '0;
    #1;
    n_checks++; if (col_start !== 1'b0) $display("FAIL rmid_start_now: got %b want 0", col_start); else n_pass++;
    @(negedge clk);
    n_checks++; if (row_idx !== '0 || busy !== 1'b0 || iter_count !== '0)
      $display("FAIL rmid_cleared: got row=%0d busy=%b iter=%0d want 0 0 0", row_idx, busy, iter_count); else n_pass++;
    reset = 1'b0; run = 1'b1;
    clear_sb();
    repeat (10) @(negedge clk);
    n_checks++; if (obs_rows.size() != 0 || busy !== 1'b0)
      $display("FAIL rmid_init_wait: got starts=%0d busy=%b want 0 0", obs_rows.size(), busy); else n_pass++;
    col_init = '1; ok = 1'b0; n = -1;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (col_start) begin ok = 1'b1; n = row_idx; end
    end
    n_checks++; if (!ok || n != 0) $display("FAIL rmid_restart: got found=%b row=%0d want 1 0", ok, n); else n_pass++;
    run = 1'b0;
    wait_idle(500, ok);
  endtask

  task automatic test_watchdog();
    bit ok = 1'b0;
    int s = 0;
    do_reset();
    height = '0; set_lat(4); stuck = 16'h0020;
    pulse_step();
    for (int i = 0; i < 20 && !ok; i++) begin
      if (col_start) begin ok = 1'b1; s = cyc; end
      else @(negedge clk);
    end
    n_checks++; if (!ok) $display("FAIL wd_start: got no start want one"); else n_pass++;
`ifdef GRID_WATCHDOG_EN
    begin
      int  f = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (fault) begin seen = 1'b1; f = cyc; end
      end
      // ISSUE, ARM, then 20 WAIT_DONE cycles before FAULT is entered.
      n_checks++; if (!seen || (f - s) != 22)
        $display("FAIL wd_fault_time: got seen=%b delay=%0d want 1 22", seen, f - s); else n_pass++;
      repeat (30) @(negedge clk);
      n_checks++; if (fault !== 1'b1 || obs_rows.size() != 1 || busy !== 1'b0)
        $display("FAIL wd_hold: got fault=%b starts=%0d busy=%b want 1 1 0", fault, obs_rows.size(), busy); else n_pass++;
    end
`else
    repeat (60) @(negedge clk);
    n_checks++; if (fault !== 1'b0) $display("FAIL wd_off_fault: got %b want 0", fault); else n_pass++;
    n_checks++; if (busy !== 1'b1 || obs_rows.size() != 1)
      $display("FAIL wd_off_wait: got busy=%b starts=%0d want 1 1", busy, obs_rows.size()); else n_pass++;
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_single_step();
    test_staggered();
    test_iter_limit();
    test_run_drop();
    test_reset_mid();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion want summary");
    $fatal(1, "bench timeout");
  end

endmodule
